// File: rtl/commit_trace_fifo_if.sv
// rtl/commit_trace_fifo_if.sv - commit-side inputs and trace-side stream of the commit trace FIFO
interface commit_trace_fifo_if;
  logic [1:0]       commit_ack_i;
  logic [1:0][63:0] commit_pc_i;
  logic [1:0][31:0] commit_instr_i;
  logic [1:0][4:0]  commit_waddr_i;
  logic [1:0][63:0] commit_wdata_i;
  logic [1:0][2:0]  commit_we_i;
  logic [1:0]       priv_lvl_i;

  logic             trace_valid_o;
  logic             trace_ready_i;
  logic [31:0]      trace_seq_o;
  logic [63:0]      trace_pc_o;
  logic [31:0]      trace_instr_o;
  logic [4:0]       trace_waddr_o;
  logic [63:0]      trace_wdata_o;
  logic [2:0]       trace_we_o;
  logic [1:0]       trace_priv_o;

  modport master (
    output commit_ack_i, commit_pc_i, commit_instr_i, commit_waddr_i,
           commit_wdata_i, commit_we_i, priv_lvl_i, trace_ready_i,
    input  trace_valid_o, trace_seq_o, trace_pc_o, trace_instr_o,
           trace_waddr_o, trace_wdata_o, trace_we_o, trace_priv_o
  );

  modport slave (
    input  commit_ack_i, commit_pc_i, commit_instr_i, commit_waddr_i,
           commit_wdata_i, commit_we_i, priv_lvl_i, trace_ready_i,
    output trace_valid_o, trace_seq_o, trace_pc_o, trace_instr_o,
           trace_waddr_o, trace_wdata_o, trace_we_o, trace_priv_o
  );
endinterface

// File: rtl/commit_trace_fifo.sv
// rtl/commit_trace_fifo.sv - in-order trace FIFO for two commit ports with sequence stamping and drop counting
module commit_trace_fifo #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  commit_trace_fifo_if.slave   bus,
  output logic [CNT_W-1:0]     drop_cnt_o,
  output logic                 overflow_o
);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [31:0] seq;
    logic [63:0] pc;
    logic [31:0] instr;
    logic [4:0]  waddr;
    logic [63:0] wdata;
    logic [2:0]  we;
    logic [1:0]  priv;
  } rec_t;

  rec_t          mem [DEPTH];
  rec_t          rec0, rec1, head;
  logic [AW-1:0] rd_ptr, wr_ptr, wr_ptr_p1;
  logic [AW:0]   count, count_next, free;
  logic [31:0]   seq_q;
  logic [1:0]    n_ack, n_push, n_drop;
  logic          first, valid, pop;
  logic [CNT_W:0]   drop_sum;
  logic [CNT_W-1:0] drop_next;

  assign valid     = (count != '0);
  assign pop       = valid && bus.trace_ready_i && !flush_i;
  assign n_ack     = {1'b0, bus.commit_ack_i[0]} + {1'b0, bus.commit_ack_i[1]};
  assign free      = (AW+1)'(DEPTH) - count;
  assign wr_ptr_p1 = wr_ptr + AW'(1);

  // Room is judged on the start-of-cycle count; a same-cycle pop frees nothing.
  always_comb begin
    n_push = 2'd0;
    if (!flush_i) begin
      if (free >= (AW+1)'(n_ack)) n_push = n_ack;
      else                        n_push = free[1:0];
    end
  end

  assign n_drop     = n_ack - n_push;
  assign count_next = count + (AW+1)'(n_push) - (AW+1)'(pop);
  assign drop_sum   = {1'b0, drop_cnt_o} + (CNT_W+1)'(n_drop);
  assign drop_next  = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];

  // The oldest acked port always takes the current seq value, even when only port 1 commits.
  always_comb begin
    first       = bus.commit_ack_i[0] ? 1'b0 : 1'b1;
    rec0.seq    = seq_q;
    rec0.pc     = bus.commit_pc_i[first];
    rec0.instr  = bus.commit_instr_i[first];
    rec0.waddr  = bus.commit_waddr_i[first];
    rec0.wdata  = bus.commit_wdata_i[first];
    rec0.we     = bus.commit_we_i[first];
    rec0.priv   = bus.priv_lvl_i;
    rec1.seq    = seq_q + 32'd1;
    rec1.pc     = bus.commit_pc_i[1];
    rec1.instr  = bus.commit_instr_i[1];
    rec1.waddr  = bus.commit_waddr_i[1];
    rec1.wdata  = bus.commit_wdata_i[1];
    rec1.we     = bus.commit_we_i[1];
    rec1.priv   = bus.priv_lvl_i;
  end

  always_ff @(posedge clk_i) begin
    if (n_push != 2'd0) mem[wr_ptr]    <= rec0;
    if (n_push == 2'd2) mem[wr_ptr_p1] <= rec1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count      <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      seq_q      <= '0;
      drop_cnt_o <= '0;
      overflow_o <= 1'b0;
    end else begin
      seq_q      <= seq_q + 32'(n_ack);
      drop_cnt_o <= drop_next;
      if (n_drop != 2'd0) overflow_o <= 1'b1;
      if (flush_i) begin
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        count  <= count_next;
        wr_ptr <= wr_ptr + AW'(n_push);
        rd_ptr <= rd_ptr + AW'(pop);
      end
    end
  end

  assign head              = valid ? mem[rd_ptr] : '0;
  assign bus.trace_valid_o = valid;
  assign bus.trace_seq_o   = head.seq;
  assign bus.trace_pc_o    = head.pc;
  assign bus.trace_instr_o = head.instr;
  assign bus.trace_waddr_o = head.waddr;
  assign bus.trace_wdata_o = head.wdata;
  assign bus.trace_we_o    = head.we;
  assign bus.trace_priv_o  = head.priv;
endmodule

// File: doc/commit_trace_fifo.md
Name: commit_trace_fifo

Overview:
- Captures committed instructions from the two commit ports, together with their write-back data. Queues them in order and drains them one record per cycle over a valid/ready stream to the trace sink (trace encoder or debug DMA).
- Sits directly downstream of the commit stage, alongside the tracer interface.
- Stamps every commit with a sequence number so the sink can detect drops. Drops are also counted and flagged.

Parameters:
- DEPTH, 8, FIFO entries; must be a power of two and ≥2.
- CNT_W, 16, width of the saturating drop counter.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  synchronous clear of queued records
- commit_ack_i  in  2  commit valid per port; port 0 is older
- commit_pc_i  in  2x64  PC per port
- commit_instr_i  in  2x32  instruction word per port
- commit_waddr_i  in  2x5  destination register per port
- commit_wdata_i  in  2x64  write-back data per port
- commit_we_i  in  2x3  {posr, fpr, gpr} write enables per port
- priv_lvl_i  in  2  current privilege level, shared by both ports
- trace_valid_o  out  1  head record valid
- trace_ready_i  in  1  sink accepts head record
- trace_seq_o  out  32  sequence number of head record
- trace_pc_o  out  64  head record PC
- trace_instr_o  out  32  head record instruction
- trace_waddr_o  out  5  head record waddr
- trace_wdata_o  out  64  head record wdata
- trace_we_o  out  3  head record write enables
- trace_priv_o  out  2  head record privilege
- drop_cnt_o  out  CNT_W  saturating count of dropped commits
- overflow_o  out  1  sticky: at least one drop since reset

Behaviour:
- Reset (async, rst_ni=0):
  - FIFO empty, pointers 0, seq counter 0, drop_cnt_o=0, overflow_o=0.
  - trace_valid_o=0. All record outputs read as 0 while empty (muxed to zero).
- Record contents:
  - {seq, pc, instr, waddr, wdata, we, priv}.
  - priv is sampled in the push cycle.
- Sequence numbering:
  - Each acked port consumes one seq value in port order (port 0 then port 1). Only acked ports consume a value.
  - The counter advances by popcount(commit_ack_i) every cycle, whether the records are stored or dropped. It wraps modulo 2^32.
  - If only port 1 is acked, it is treated as a single commit and takes the next seq value.
- Free space:
  - free = DEPTH − count, using count at the start of the cycle. A pop in the same cycle does not create room for that cycle's pushes.
- Push rule:
  - Write min(free, n_acked) records in port order.
  - Remaining acked commits are dropped.
  - drop_cnt_o += number dropped, saturating at 2^CNT_W−1.
  - overflow_o is set on any drop and cleared only by reset.
- Pop:
  - Happens when trace_valid_o && trace_ready_i.
  - The head advances by one. The next record appears on the following cycle (registered count; outputs combinationally read from the head slot).
  - trace_valid_o = (count != 0).
  - Outputs hold stable while valid && !ready.
- Latency: a record pushed in cycle N is visible at the head no earlier than cycle N+1.
- Count update: count_next = count + pushed − popped. Pointers wrap modulo DEPTH.
- Flush (flush_i=1):
  - count, read pointer and write pointer return to 0. Any pop that cycle is void.
  - Commits acked in the flush cycle are discarded and counted as dropped; overflow_o is set.
  - The seq counter still advances. drop_cnt_o and overflow_o are not cleared by flush.
- Handshake violations: asserting trace_ready_i while empty has no effect.
- Concurrency: both ports acked, with a pop, at count=DEPTH−1 → one push (port 0), one drop (port 1), one pop; count ends at DEPTH−1.

Test Plan:
- Reset, then one commit on port 0 (pc=0x8000_0000, instr=0x0010_0093) with ready=1 → cycle+1: valid=1, seq=0, pc=0x8000_0000; cycle+2: valid=0.
- Both ports acked for 4 cycles, ready=0, DEPTH=8 → 8 records with seq 0..7 in port-0-first order. No drops, overflow=0.
- Full FIFO (8 entries), dual commit with ready=1 → both commits dropped (seq 8 and 9 consumed), drop_cnt=2, overflow=1. Drained seqs are 0..7; the next commit gets seq 10.
- count=7, dual commit with pop → port 0 stored as seq N, port 1 dropped, count=7, drop_cnt+1.
- flush_i with 5 queued entries plus a port-0 commit in the same cycle → valid=0 next cycle, drop_cnt+1, seq counter advanced by 1. A following commit is delivered with the correct seq.
- Force drop_cnt to 2^16−2, then trigger 3 drops → drop_cnt saturates at 0xFFFF. Assert rst_ni low mid-stream → all outputs return to reset values asynchronously.
